elevator_scan_ctrl: RTL and testbench

- Parametrised elevator car controller and next generation of the single-floor one-hot tracker.
- Latches floor-call requests for N floors and moves the car one floor at a time using SCAN ordering: keep travelling in the current direction while calls remain ahead.
- Times floor-to-floor travel and door dwell from a prescaled tick, and supports a door-hold input.
- Sits between the floor-select input decode and the floor display/indicator outputs.

---
 rtl/elevator_pkg.sv | 37 +++
 rtl/elevator_tick_gen.sv | 42 ++++
 rtl/elevator_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types, defaults and call-mask helpers for the elevator controller.
package elevator_pkg;

   localparam int unsigned NUM_FLOORS_DEF = 8;
   localparam int unsigned TICK_DIV_DEF   = 16777216;
   localparam int unsigned MAX_FLOORS     = 32;
   localparam int unsigned MAX_FLOOR_W    = 5;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_MOVING    = 2'd1,
      ST_DOOR_OPEN = 2'd2
   } elev_state_e;

   // True when any call in mask lies strictly above floor.
   function automatic logic any_above(input logic [MAX_FLOORS-1:0]  mask,
                                      input logic [MAX_FLOOR_W-1:0] floor);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < int'(MAX_FLOORS); i++) begin
         if ((i > int'(floor)) && mask[i]) hit = 1'b1;
      end
      return hit;
   endfunction

   // True when any call in mask lies strictly below floor.
   function automatic logic any_below(input logic [MAX_FLOORS-1:0]  mask,
                                      input logic [MAX_FLOOR_W-1:0] floor);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < int'(MAX_FLOORS); i++) begin
         if ((i < int'(floor)) && mask[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/elevator_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV cycles, restarted by clr.
module elevator_tick_gen
   import elevator_pkg::*;
#(
   parameter int unsigned TICK_DIV = TICK_DIV_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick_o
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // Tick is registered, so it is raised one count early to land on cycle TICK_DIV.
   always_comb begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = (cnt_q == CNT_W'(TICK_DIV - 2));
      if (cnt_q == CNT_W'(TICK_DIV - 1)) cnt_d = '0;
      if (clr) begin
         cnt_d  = '0;
         tick_d = 1'b0;
      end
   end

   // Prescaler registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick_o = tick_q;

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN-ordered elevator car controller with latched calls, move/door timing and door hold.
module elevator_scan_ctrl
   import elevator_pkg::*;
#(
   parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEF,
   parameter int unsigned FLOOR_W    = $clog2(NUM_FLOORS),
   parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
   parameter int unsigned MOVE_TICKS = 2,
   parameter int unsigned DOOR_TICKS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] req_i,
   input  logic                  door_hold_i,
   output logic [FLOOR_W-1:0]    floor_o,
   output logic [NUM_FLOORS-1:0] floor_onehot_o,
   output logic                  dir_up_o,
   output logic                  moving_o,
   output logic                  door_open_o,
   output logic [NUM_FLOORS-1:0] pending_o
);

   localparam int unsigned TMR_MAX = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [NUM_FLOORS-1:0] ONE_HOT0 = NUM_FLOORS'(1);

   elev_state_e             state_q, state_d;
   logic [FLOOR_W-1:0]      floor_q, floor_d;
   logic [NUM_FLOORS-1:0]   onehot_q, onehot_d;
   logic                    dir_up_q, dir_up_d;
   logic                    moving_q, moving_d;
   logic                    door_open_q, door_open_d;
   logic [NUM_FLOORS-1:0]   pending_q, pending_d;
   logic [TMR_W-1:0]        timer_q, timer_d;
   logic [NUM_FLOORS-1:0]   clear_mask_c;
   logic                    tick_clr_c;
   logic                    tick;
   logic                    above_c, below_c;

   elevator_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .clr    (tick_clr_c),
      .tick_o (tick)
   );

   // Next-state, floor stepping, timer and call-latch logic.
   always_comb begin
      state_d      = state_q;
      floor_d      = floor_q;
      dir_up_d     = dir_up_q;
      timer_d      = timer_q;
      tick_clr_c   = 1'b0;
      clear_mask_c = '0;
      above_c      = 1'b0;
      below_c      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            above_c = any_above(MAX_FLOORS'(pending_q), MAX_FLOOR_W'(floor_q));
            below_c = any_below(MAX_FLOORS'(pending_q), MAX_FLOOR_W'(floor_q));
            if (pending_q[floor_q]) begin
               state_d      = ST_DOOR_OPEN;
               timer_d      = '0;
               tick_clr_c   = 1'b1;
               clear_mask_c = ONE_HOT0 << floor_q;
            end else if (above_c || below_c) begin
               if (!(above_c && below_c)) dir_up_d = above_c;
               state_d    = ST_MOVING;
               timer_d    = '0;
               tick_clr_c = 1'b1;
            end
         end

         ST_MOVING: begin
            if (tick) begin
               if (timer_q == TMR_W'(MOVE_TICKS - 1)) begin
                  // Arrival: step the floor and decide on the new floor in the same edge.
                  floor_d    = dir_up_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
                  above_c    = any_above(MAX_FLOORS'(pending_q), MAX_FLOOR_W'(floor_d));
                  below_c    = any_below(MAX_FLOORS'(pending_q), MAX_FLOOR_W'(floor_d));
                  timer_d    = '0;
                  tick_clr_c = 1'b1;
                  if (pending_q[floor_d]) begin
                     state_d      = ST_DOOR_OPEN;
                     clear_mask_c = ONE_HOT0 << floor_d;
                  end else if (dir_up_q ? above_c : below_c) begin
                     state_d = ST_MOVING;
                  end else if (dir_up_q ? below_c : above_c) begin
                     dir_up_d = ~dir_up_q;
                     state_d  = ST_MOVING;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
         end

         ST_DOOR_OPEN: begin
            if (req_i[floor_q] || door_hold_i) begin
               timer_d      = '0;
               tick_clr_c   = 1'b1;
               clear_mask_c = ONE_HOT0 << floor_q;
            end else if (tick) begin
               if (timer_q == TMR_W'(DOOR_TICKS - 1)) begin
                  state_d = ST_IDLE;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      pending_d   = (pending_q | req_i) & ~clear_mask_c;
      onehot_d    = ONE_HOT0 << floor_d;
      moving_d    = (state_d == ST_MOVING);
      door_open_d = (state_d == ST_DOOR_OPEN);
   end

   // State, floor, direction, flag and call registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         floor_q     <= '0;
         onehot_q    <= ONE_HOT0;
         dir_up_q    <= 1'b1;
         moving_q    <= 1'b0;
         door_open_q <= 1'b0;
         pending_q   <= '0;
         timer_q     <= '0;
      end else begin
         state_q     <= state_d;
         floor_q     <= floor_d;
         onehot_q    <= onehot_d;
         dir_up_q    <= dir_up_d;
         moving_q    <= moving_d;
         door_open_q <= door_open_d;
         pending_q   <= pending_d;
         timer_q     <= timer_d;
      end
   end

   assign floor_o        = floor_q;
   assign floor_onehot_o = onehot_q;
   assign dir_up_o       = dir_up_q;
   assign moving_o       = moving_q;
   assign door_open_o    = door_open_q;
   assign pending_o      = pending_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: cycle-countdown reference model plus directed literal checks.
module tb_elevator_scan_ctrl;

   localparam int unsigned NF       = 8;
   localparam int unsigned FW       = 3;
   localparam int unsigned TD       = 4;
   localparam int unsigned MT       = 2;
   localparam int unsigned DT       = 3;
   localparam int          MOVE_CYC = MT * TD;
   localparam int          DOOR_CYC = DT * TD;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NF-1:0] req = '0;
   logic          hold = 1'b0;
   logic [FW-1:0] floor_o;
   logic [NF-1:0] floor_onehot_o;
   logic          dir_up_o;
   logic          moving_o;
   logic          door_open_o;
   logic [NF-1:0] pending_o;

   int n_checks = 0;
   int n_fail   = 0;

   elevator_scan_ctrl #(
      .NUM_FLOORS (NF),
      .TICK_DIV   (TD),
      .MOVE_TICKS (MT),
      .DOOR_TICKS (DT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .req_i          (req),
      .door_hold_i    (hold),
      .floor_o        (floor_o),
      .floor_onehot_o (floor_onehot_o),
      .dir_up_o       (dir_up_o),
      .moving_o       (moving_o),
      .door_open_o    (door_open_o),
      .pending_o      (pending_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: modes 0 idle, 1 moving, 2 door open; m_left counts clk cycles left.
   int            m_floor = 0;
   int            m_mode  = 0;
   int            m_left  = 0;
   bit            m_dir   = 1'b1;
   bit            m_valid = 1'b0;
   logic [NF-1:0] m_pend  = '0;

   function automatic bit calls_above(input logic [NF-1:0] p, input int f);
      for (int i = f + 1; i < int'(NF); i++) if (p[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit calls_below(input logic [NF-1:0] p, input int f);
      for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk) begin : model
      logic [NF-1:0] p;
      logic [NF-1:0] clr;
      bit up;
      bit dn;
      if (rst) begin
         m_valid = 1'b1;
         m_floor = 0;
         m_mode  = 0;
         m_left  = 0;
         m_dir   = 1'b1;
         m_pend  = '0;
      end else if (m_valid) begin
         p   = m_pend;
         clr = '0;
         case (m_mode)
            0: begin
               up = calls_above(p, m_floor);
               dn = calls_below(p, m_floor);
               if (p[m_floor]) begin
                  m_mode = 2; m_left = DOOR_CYC; clr[m_floor] = 1'b1;
               end else if (up || dn) begin
                  if (!(up && dn)) m_dir = up;
                  m_mode = 1; m_left = MOVE_CYC;
               end
            end
            1: begin
               m_left--;
               if (m_left == 0) begin
                  m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                  up = calls_above(p, m_floor);
                  dn = calls_below(p, m_floor);
                  if (p[m_floor]) begin
                     m_mode = 2; m_left = DOOR_CYC; clr[m_floor] = 1'b1;
                  end else if (m_dir ? up : dn) begin
                     m_left = MOVE_CYC;
                  end else if (m_dir ? dn : up) begin
                     m_dir = ~m_dir; m_left = MOVE_CYC;
                  end else begin
                     m_mode = 0;
                  end
               end
            end
            default: begin
               if (req[m_floor] || hold) begin
                  m_left = DOOR_CYC; clr[m_floor] = 1'b1;
               end else begin
                  m_left--;
                  if (m_left == 0) m_mode = 0;
               end
            end
         endcase
         m_pend = (p | req) & ~clr;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [NF-1:0] one;
      if (m_valid) begin
         one = NF'(1);
         chk("model_floor",   32'(floor_o),        32'(m_floor));
         chk("model_onehot",  32'(floor_onehot_o), 32'(one << m_floor));
         chk("model_dir",     32'(dir_up_o),       32'(m_dir));
         chk("model_moving",  32'(moving_o),       32'(m_mode == 1));
         chk("model_door",    32'(door_open_o),    32'(m_mode == 2));
         chk("model_pending", 32'(pending_o),      32'(m_pend));
      end
   end

   task automatic pulse(input logic [NF-1:0] v);
      req = v;
      @(negedge clk);
      req = '0;
   endtask

   task automatic wait_door_open(input int budget, input int exp_floor, input string tag);
      int n = 0;
      while (door_open_o !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_door_open"}, 32'(door_open_o), 32'd1);
      chk({tag, "_floor"},     32'(floor_o),     32'(exp_floor));
   endtask

   task automatic wait_door_close(input int budget, input string tag);
      int n = 0;
      while (door_open_o !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_door_closed"}, 32'(door_open_o), 32'd0);
   endtask

   initial begin
      // Reset for two cycles.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_floor",   32'(floor_o),        32'd0);
      chk("rst_onehot",  32'(floor_onehot_o), 32'h01);
      chk("rst_dir",     32'(dir_up_o),       32'd1);
      chk("rst_pending", 32'(pending_o),      32'd0);
      chk("rst_moving",  32'(moving_o),       32'd0);
      chk("rst_door",    32'(door_open_o),    32'd0);

      // Call to floor 3 from idle at floor 0.
      pulse(8'h08);
      chk("t1_pending", 32'(pending_o), 32'h08);
      chk("t1_not_yet_moving", 32'(moving_o), 32'd0);
      @(negedge clk);
      chk("t1_moving", 32'(moving_o), 32'd1);
      repeat (7) @(negedge clk);
      chk("t1_floor0_hold", 32'(floor_o), 32'd0);
      @(negedge clk);
      chk("t1_floor1", 32'(floor_o), 32'd1);
      repeat (8) @(negedge clk);
      chk("t1_floor2", 32'(floor_o), 32'd2);
      repeat (8) @(negedge clk);
      chk("t1_floor3",   32'(floor_o),     32'd3);
      chk("t1_door",     32'(door_open_o), 32'd1);
      chk("t1_cleared",  32'(pending_o),   32'd0);
      chk("t1_stopped",  32'(moving_o),    32'd0);
      repeat (11) @(negedge clk);
      chk("t1_door_11", 32'(door_open_o), 32'd1);
      @(negedge clk);
      chk("t1_door_12", 32'(door_open_o), 32'd0);

      // SCAN: heading for 6, calls at 1 and 5 added during the move from 3.
      pulse(8'h40);
      @(negedge clk);
      repeat (2) @(negedge clk);
      pulse(8'h22);
      wait_door_open(40, 5, "t2_stop5");
      chk("t2_dir_at5", 32'(dir_up_o), 32'd1);
      wait_door_close(20, "t2_stop5");
      wait_door_open(40, 6, "t2_stop6");
      wait_door_close(20, "t2_stop6");
      wait_door_open(80, 1, "t2_stop1");
      chk("t2_dir_down",  32'(dir_up_o),  32'd0);
      chk("t2_pending0",  32'(pending_o), 32'd0);
      wait_door_close(20, "t2_stop1");

      // Go to floor 2, then a call at the current floor opens the door in place.
      pulse(8'h04);
      wait_door_open(40, 2, "t3_go2");
      wait_door_close(20, "t3_go2");
      pulse(8'h04);
      chk("t3_latched", 32'(pending_o),   32'h04);
      chk("t3_closed",  32'(door_open_o), 32'd0);
      @(negedge clk);
      chk("t3_door",    32'(door_open_o), 32'd1);
      chk("t3_floor",   32'(floor_o),     32'd2);
      chk("t3_moving",  32'(moving_o),    32'd0);
      chk("t3_pending", 32'(pending_o),   32'd0);

      // Door hold for 40 cycles, then a full dwell after release.
      hold = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("t4_held_open", 32'(door_open_o), 32'd1);
      end
      hold = 1'b0;
      repeat (11) @(negedge clk);
      chk("t4_door_11", 32'(door_open_o), 32'd1);
      @(negedge clk);
      chk("t4_door_12", 32'(door_open_o), 32'd0);

      // Reset while moving between floors 4 and 5 with calls at 0 and 7.
      pulse(8'h81);
      begin
         int n = 0;
         while (floor_o !== FW'(4) && n < 60) begin
            @(negedge clk);
            n++;
         end
      end
      repeat (3) @(negedge clk);
      chk("t5_floor4",   32'(floor_o),   32'd4);
      chk("t5_moving",   32'(moving_o),  32'd1);
      chk("t5_pending",  32'(pending_o), 32'h81);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_rst_floor",   32'(floor_o),        32'd0);
      chk("t5_rst_onehot",  32'(floor_onehot_o), 32'h01);
      chk("t5_rst_pending", 32'(pending_o),      32'd0);
      chk("t5_rst_moving",  32'(moving_o),       32'd0);
      chk("t5_rst_door",    32'(door_open_o),    32'd0);
      chk("t5_rst_dir",     32'(dir_up_o),       32'd1);
      repeat (5) @(negedge clk);
      chk("t5_no_door", 32'(door_open_o), 32'd0);
      chk("t5_idle",    32'(moving_o),    32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
